// File: rtl/axi_full_burst_slave_mem.sv
// AXI4 burst slave memory: independent INCR/FIXED write and read burst engines
// in front of a word-addressed register array with byte-strobed writes.
module axi_full_burst_slave_mem #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int MEM_WORDS          = 256
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                      S_AXI_AWLEN,
   input  logic [1:0]                      S_AXI_AWBURST,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WLAST,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                      S_AXI_ARLEN,
   input  logic [1:0]                      S_AXI_ARBURST,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RLAST,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam int              IDXW        = C_S_AXI_ADDR_WIDTH - 2;
   localparam int              MW          = $clog2(MEM_WORDS);
   localparam logic [IDXW-1:0] MEM_LIMIT   = IDXW'(MEM_WORDS);
   localparam logic [1:0]      BURST_INCR  = 2'b01;
   localparam logic [1:0]      RESP_OKAY   = 2'b00;
   localparam logic [1:0]      RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
   typedef enum logic       {R_IDLE, R_DATA}         rState_t;

   logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

   wState_t         r_wState, w_wStateNext;
   logic            r_awready, r_wready, r_bvalid;
   logic            w_awreadyNext, w_wreadyNext, w_bvalidNext;
   logic [1:0]      r_bresp;
   logic [IDXW-1:0] r_wIdx;
   logic [7:0]      r_awLen;
   logic            r_wIncr, r_wBad, r_wErr, r_wPast;
   logic [8:0]      r_wBeat;
   logic            w_awHs, w_wHs, w_bHs;
   logic            w_wInRange, w_wBeyond, w_wErrNow, w_wEn;
   logic [MW-1:0]   w_wMemIdx;

   rState_t                       r_rState, w_rStateNext;
   logic                          r_arready, r_rvalid, r_rlast;
   logic                          w_arreadyNext, w_rvalidNext, w_rLoad;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                    r_rresp;
   logic [IDXW-1:0]               r_rIdx;
   logic [7:0]                    r_arLen, r_rBeat;
   logic                          r_rIncr, r_rBad;
   logic                          w_arHs, w_rHs;
   logic [IDXW-1:0]               w_rLoadIdx;
   logic                          w_rLoadBad, w_rLoadLast, w_rLoadOk;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rMemWord;
   logic                          w_unusedAddrBits;

   assign w_unusedAddrBits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RLAST   = r_rlast;

   assign w_awHs = S_AXI_AWVALID && r_awready;
   assign w_wHs  = S_AXI_WVALID && r_wready;
   assign w_bHs  = r_bvalid && S_AXI_BREADY;
   assign w_arHs = S_AXI_ARVALID && r_arready;
   assign w_rHs  = r_rvalid && S_AXI_RREADY;

   // A beat is "beyond" once more than AWLEN+1 beats have been seen; the sticky
   // flag keeps that true even if the 9-bit beat counter wraps on a runaway burst.
   assign w_wInRange = (r_wIdx < MEM_LIMIT);
   assign w_wBeyond  = r_wPast || (r_wBeat > {1'b0, r_awLen});
   assign w_wErrNow  = r_wErr || !w_wInRange ||
                       (S_AXI_WLAST && (w_wBeyond || (r_wBeat != {1'b0, r_awLen})));
   assign w_wEn      = w_wHs && !r_wBad && w_wInRange && !w_wBeyond;
   assign w_wMemIdx  = r_wIdx[MW-1:0];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_wState <= W_IDLE;
      else          r_wState <= w_wStateNext;
   end

   always_comb begin
      w_wStateNext = r_wState;
      case (r_wState)
         W_IDLE:  if (w_awHs)                w_wStateNext = W_DATA;
         W_DATA:  if (w_wHs && S_AXI_WLAST)  w_wStateNext = W_RESP;
         W_RESP:  if (w_bHs)                 w_wStateNext = W_IDLE;
         default:                            w_wStateNext = W_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they read 0 in reset
   // and rise on the first clock edge afterwards.
   always_comb begin
      w_awreadyNext = (w_wStateNext == W_IDLE);
      w_wreadyNext  = (w_wStateNext == W_DATA);
      w_bvalidNext  = (w_wStateNext == W_RESP);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_wIdx    <= '0;
         r_awLen   <= '0;
         r_wIncr   <= 1'b0;
         r_wBad    <= 1'b0;
         r_wErr    <= 1'b0;
         r_wPast   <= 1'b0;
         r_wBeat   <= '0;
      end else begin
         r_awready <= w_awreadyNext;
         r_wready  <= w_wreadyNext;
         r_bvalid  <= w_bvalidNext;
         if (w_awHs) begin
            r_wIdx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            r_awLen <= S_AXI_AWLEN;
            r_wIncr <= (S_AXI_AWBURST == BURST_INCR);
            r_wBad  <= S_AXI_AWBURST[1];
            r_wErr  <= S_AXI_AWBURST[1];
            r_wPast <= 1'b0;
            r_wBeat <= '0;
         end
         if (w_wHs) begin
            r_wBeat <= r_wBeat + 9'd1;
            r_wErr  <= w_wErrNow;
            if (r_wIncr)   r_wIdx  <= r_wIdx + 1'b1;
            if (w_wBeyond) r_wPast <= 1'b1;
            if (S_AXI_WLAST) r_bresp <= w_wErrNow ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (w_wEn) begin
         for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
            if (S_AXI_WSTRB[b]) r_mem[w_wMemIdx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_rState <= R_IDLE;
      else          r_rState <= w_rStateNext;
   end

   always_comb begin
      w_rStateNext = r_rState;
      case (r_rState)
         R_IDLE:  if (w_arHs)           w_rStateNext = R_DATA;
         R_DATA:  if (w_rHs && r_rlast) w_rStateNext = R_IDLE;
         default:                       w_rStateNext = R_IDLE;
      endcase
   end

   always_comb begin
      w_arreadyNext = (w_rStateNext == R_IDLE);
      w_rvalidNext  = (w_rStateNext == R_DATA);
      w_rLoad       = w_arHs || (w_rHs && !r_rlast);
   end

   // The beat register is loaded straight from the AR request for the first beat
   // and from the advanced index afterwards, so bursts stream without bubbles.
   always_comb begin
      if (r_rState == R_IDLE) begin
         w_rLoadIdx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
         w_rLoadBad  = S_AXI_ARBURST[1];
         w_rLoadLast = (S_AXI_ARLEN == 8'd0);
      end else begin
         w_rLoadIdx  = r_rIncr ? r_rIdx + 1'b1 : r_rIdx;
         w_rLoadBad  = r_rBad;
         w_rLoadLast = ((r_rBeat + 8'd1) == r_arLen);
      end
      w_rLoadOk  = !w_rLoadBad && (w_rLoadIdx < MEM_LIMIT);
      w_rMemWord = r_mem[w_rLoadIdx[MW-1:0]];
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rIdx    <= '0;
         r_arLen   <= '0;
         r_rBeat   <= '0;
         r_rIncr   <= 1'b0;
         r_rBad    <= 1'b0;
      end else begin
         r_arready <= w_arreadyNext;
         r_rvalid  <= w_rvalidNext;
         if (w_arHs) begin
            r_arLen <= S_AXI_ARLEN;
            r_rBeat <= '0;
            r_rIncr <= (S_AXI_ARBURST == BURST_INCR);
            r_rBad  <= S_AXI_ARBURST[1];
         end else if (w_rHs && !r_rlast) begin
            r_rBeat <= r_rBeat + 8'd1;
         end
         if (w_rLoad) begin
            r_rIdx  <= w_rLoadIdx;
            r_rdata <= w_rLoadOk ? w_rMemWord : '0;
            r_rresp <= w_rLoadOk ? RESP_OKAY : RESP_SLVERR;
            r_rlast <= w_rLoadLast;
         end else if (w_rHs) begin
            r_rlast <= 1'b0;
         end
      end
   end

endmodule
